// File: rtl/sbox_share_sched_if.sv
// sbox_share_sched_if: request/response handshake bundle shared by the state and key requesters
interface sbox_share_sched_if;
  logic         st_req_valid;
  logic         st_req_ready;
  logic [127:0] st_req_data;
  logic         st_rsp_valid;
  logic         st_rsp_ready;
  logic [127:0] st_rsp_data;
  logic         key_req_valid;
  logic         key_req_ready;
  logic [31:0]  key_req_data;
  logic         key_rsp_valid;
  logic         key_rsp_ready;
  logic [31:0]  key_rsp_data;
  logic         busy;
  modport master (
    output st_req_valid, st_req_data, st_rsp_ready, key_req_valid, key_req_data, key_rsp_ready,
    input  st_req_ready, st_rsp_valid, st_rsp_data, key_req_ready, key_rsp_valid, key_rsp_data, busy
  );
  modport slave (
    input  st_req_valid, st_req_data, st_rsp_ready, key_req_valid, key_req_data, key_rsp_ready,
    output st_req_ready, st_rsp_valid, st_rsp_data, key_req_ready, key_rsp_valid, key_rsp_data, busy
  );
endinterface

// File: rtl/sbox_share_sched.sv
// sbox_share_sched: time-multiplexes one byte-serial AES S-box between a SubBytes job and a SubWord job
module sbox_share_sched #(
  parameter int ARB_MODE = 0
) (
  input logic              clk,
  input logic              reset,
  sbox_share_sched_if.slave bus
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state, state_nx;
  logic [3:0]        count, idx;
  logic              owner, last_key, pick_key, accept, last_byte, rsp_hs;
  logic [0:15][7:0]  din, res;
  logic [7:0]        sb_out;
  always_comb begin
    pick_key = bus.key_req_valid && (!bus.st_req_valid || ARB_MODE == 1 || !last_key);
    bus.st_req_ready = !reset && state == IDLE && bus.st_req_valid && !pick_key;
    bus.key_req_ready = !reset && state == IDLE && pick_key;
    accept = bus.st_req_ready || bus.key_req_ready;
    idx = owner ? 4'd12 + count : count;
    sb_out = SBOX[din[idx]];
    last_byte = count == (owner ? 4'd3 : 4'd15);
    rsp_hs = state == DONE && (owner ? bus.key_rsp_ready : bus.st_rsp_ready);
    bus.st_rsp_valid = state == DONE && !owner;
    bus.key_rsp_valid = state == DONE && owner;
    bus.st_rsp_data = res;
    bus.key_rsp_data = res[12:15];
    bus.busy = state != IDLE;
    state_nx = (state == IDLE && accept) ? RUN :
               (state == RUN && last_byte) ? DONE :
               (state == DONE && rsp_hs) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      owner <= 1'b0;
      last_key <= 1'b0;
      din <= '0;
      res <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        din <= bus.key_req_ready ? {96'd0, bus.key_req_data} : bus.st_req_data;
        owner <= bus.key_req_ready;
        last_key <= bus.key_req_ready;
        count <= '0;
      end else if (state == RUN) begin
        res[idx] <= sb_out;
        count <= count + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_sbox_share_sched.sv
// tb_sbox_share_sched: job-level reference model checks two scheduler instances (round-robin and key priority)
module tb_sbox_share_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sbox_share_sched_if b0();
  sbox_share_sched_if b1();
  sbox_share_sched #(.ARB_MODE(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  sbox_share_sched #(.ARB_MODE(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_f(d[127-8*i -: 8]);
    return r;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[31-8*i -: 8] = sbox_f(d[31-8*i -: 8]);
    return r;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  bit m_act[2], m_own[2], m_lk[2];
  int m_acc[2];
  logic [127:0] m_exp[2];
  logic sv, kv, srr, krr, srdy, krdy, srv, krv, bsy, done, pk, e_srdy, e_krdy;
  logic [127:0] srd;
  logic [31:0] kd, krd;
  logic [127:0] sd;
  int n;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        sv = b0.st_req_valid; kv = b0.key_req_valid; srr = b0.st_rsp_ready; krr = b0.key_rsp_ready;
        sd = b0.st_req_data; kd = b0.key_req_data; srdy = b0.st_req_ready; krdy = b0.key_req_ready;
        srv = b0.st_rsp_valid; krv = b0.key_rsp_valid; bsy = b0.busy; srd = b0.st_rsp_data; krd = b0.key_rsp_data;
      end else begin
        sv = b1.st_req_valid; kv = b1.key_req_valid; srr = b1.st_rsp_ready; krr = b1.key_rsp_ready;
        sd = b1.st_req_data; kd = b1.key_req_data; srdy = b1.st_req_ready; krdy = b1.key_req_ready;
        srv = b1.st_rsp_valid; krv = b1.key_rsp_valid; bsy = b1.busy; srd = b1.st_rsp_data; krd = b1.key_rsp_data;
      end
      n = m_own[k] ? 4 : 16;
      done = m_act[k] && (cyc - m_acc[k] >= n + 1);
      pk = kv && (!sv || k == 1 || !m_lk[k]);
      e_srdy = !reset && !m_act[k] && sv && !pk;
      e_krdy = !reset && !m_act[k] && pk;
      chk($sformatf("u%0d busy", k), bsy, m_act[k]);
      chk($sformatf("u%0d st_req_ready", k), srdy, e_srdy);
      chk($sformatf("u%0d key_req_ready", k), krdy, e_krdy);
      chk($sformatf("u%0d st_rsp_valid", k), srv, done && !m_own[k]);
      chk($sformatf("u%0d key_rsp_valid", k), krv, done && m_own[k]);
      if (done && !m_own[k]) chk($sformatf("u%0d st_rsp_data", k), srd, m_exp[k]);
      if (done && m_own[k]) chk($sformatf("u%0d key_rsp_data", k), krd, m_exp[k][31:0]);
      if (reset) begin
        m_act[k] = 1'b0;
        m_lk[k] = 1'b0;
      end else if (e_krdy) begin
        m_act[k] = 1'b1; m_own[k] = 1'b1; m_acc[k] = cyc; m_lk[k] = 1'b1;
        m_exp[k] = {96'd0, sub_word(kd)};
      end else if (e_srdy) begin
        m_act[k] = 1'b1; m_own[k] = 1'b0; m_acc[k] = cyc; m_lk[k] = 1'b0;
        m_exp[k] = sub_bytes(sd);
      end else if (done && (m_own[k] ? krr : srr)) begin
        m_act[k] = 1'b0;
      end
    end
  end
  initial begin
    b1.st_req_valid = 0; b1.key_req_valid = 0; b1.st_req_data = '0; b1.key_req_data = '0;
    b1.st_rsp_ready = 1; b1.key_rsp_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      b1.st_req_valid = 1'($urandom_range(0, 1));
      b1.key_req_valid = 1'($urandom_range(0, 1));
      b1.st_req_data = {$urandom, $urandom, $urandom, $urandom};
      b1.key_req_data = $urandom;
      b1.st_rsp_ready = $urandom_range(0, 3) != 0;
      b1.key_rsp_ready = $urandom_range(0, 3) != 0;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
  task automatic wait_ready(input bit key, output int c);
    c = -1;
    for (int i = 0; i < 200 && c < 0; i++) begin
      @(negedge clk);
      if (key ? b0.key_req_ready : b0.st_req_ready) c = cyc;
    end
    if (c < 0) chk(key ? "key accept timeout" : "st accept timeout", 0, 1);
  endtask
  task automatic wait_rsp(input bit key, output int c);
    c = -1;
    for (int i = 0; i < 200 && c < 0; i++) begin
      @(negedge clk);
      if (key ? b0.key_rsp_valid : b0.st_rsp_valid) c = cyc;
    end
    if (c < 0) chk(key ? "key response timeout" : "st response timeout", 0, 1);
  endtask
  task automatic offer(input bit key, input logic [127:0] d, output int acc);
    @(posedge clk);
    #1;
    if (key) begin b0.key_req_valid = 1; b0.key_req_data = d[31:0]; end
    else begin b0.st_req_valid = 1; b0.st_req_data = d; end
    wait_ready(key, acc);
    @(posedge clk);
    #1;
    if (key) b0.key_req_valid = 0;
    else b0.st_req_valid = 0;
  endtask
  int a, v, s, c;
  logic [127:0] d, snap;
  initial begin
    b0.st_req_valid = 0; b0.key_req_valid = 0; b0.st_req_data = '0; b0.key_req_data = '0;
    b0.st_rsp_ready = 1; b0.key_rsp_ready = 1;
    chk("model sbox 00", sbox_f(8'h00), 8'h63);
    chk("model sbox 53", sbox_f(8'h53), 8'hed);
    chk("model sbox 52", sbox_f(8'h52), 8'h00);
    chk("model sbox ff", sbox_f(8'hff), 8'h16);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset st_rsp_data", b0.st_rsp_data, 0);
    chk("reset key_rsp_data", b0.key_rsp_data, 0);
    offer(0, 128'h00112233445566778899aabbccddeeff, a);
    wait_rsp(0, v);
    chk("st latency", v - a, 17);
    chk("st vector", b0.st_rsp_data, 128'h638293c31bfc33f5c4eeacea4bc12816);
    chk("st vector key_rsp_valid", b0.key_rsp_valid, 0);
    @(negedge clk);
    chk("st rsp one cycle", b0.st_rsp_valid, 0);
    offer(1, 128'hcf4f3c09, a);
    wait_rsp(1, v);
    chk("key latency", v - a, 5);
    chk("key vector", b0.key_rsp_data, 32'h8a84eb01);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    b0.st_req_valid = 1; b0.st_req_data = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    b0.key_req_valid = 1; b0.key_req_data = 32'h01020304;
    @(negedge clk);
    a = cyc;
    chk("tie after reset key ready", b0.key_req_ready, 1);
    chk("tie after reset st ready", b0.st_req_ready, 0);
    @(posedge clk);
    #1 b0.key_req_valid = 0;
    wait_ready(0, s);
    chk("st accept after key rsp", s - a, 6);
    @(posedge clk);
    #1 b0.key_req_valid = 1; b0.key_req_data = 32'hdeadbeef;
    wait_ready(1, c);
    chk("alternation key wins", c - s, 18);
    chk("alternation st blocked", b0.st_req_ready, 0);
    @(posedge clk);
    #1 b0.st_req_valid = 0; b0.key_req_valid = 0;
    wait_rsp(1, v);
    b0.st_rsp_ready = 0;
    d = 128'h3243f6a8885a308d313198a2e0370734;
    offer(0, d, a);
    b0.key_req_valid = 1; b0.key_req_data = 32'h2b7e1516;
    wait_rsp(0, v);
    snap = b0.st_rsp_data;
    chk("backpressure data", snap, sub_bytes(d));
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("backpressure stable", b0.st_rsp_data, snap);
      chk("backpressure busy", b0.busy, 1);
      chk("backpressure key_req_ready", b0.key_req_ready, 0);
    end
    @(posedge clk);
    #1 b0.st_rsp_ready = 1;
    @(negedge clk);
    chk("release st_rsp_valid", b0.st_rsp_valid, 1);
    @(negedge clk);
    chk("release idle busy", b0.busy, 0);
    chk("release key accepted", b0.key_req_ready, 1);
    @(posedge clk);
    #1 b0.key_req_valid = 0;
    wait_rsp(1, v);
    offer(0, 128'hffeeddccbbaa99887766554433221100, a);
    repeat (7) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("mid-run reset busy", b0.busy, 0);
    chk("mid-run reset st_rsp_valid", b0.st_rsp_valid, 0);
    chk("mid-run reset key_rsp_valid", b0.key_rsp_valid, 0);
    offer(1, 128'h09cf4f3c, a);
    wait_rsp(1, v);
    chk("post-reset key vector", b0.key_rsp_data, 32'h018a84eb);
    for (int j = 0; j < 64; j++) begin
      for (int i = 0; i < 16; i++) d[127-8*i -: 8] = 8'((j * 16 + i) & 255);
      offer(0, d, a);
      wait_rsp(0, v);
      chk($sformatf("exhaustive job %0d", j), b0.st_rsp_data, sub_bytes(d));
    end
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      b0.st_req_valid = 1'($urandom_range(0, 1));
      b0.key_req_valid = 1'($urandom_range(0, 1));
      b0.st_req_data = {$urandom, $urandom, $urandom, $urandom};
      b0.key_req_data = $urandom;
      b0.st_rsp_ready = $urandom_range(0, 3) != 0;
      b0.key_rsp_ready = $urandom_range(0, 3) != 0;
    end
    @(posedge clk);
    #1 b0.st_req_valid = 0; b0.key_req_valid = 0; b0.st_rsp_ready = 1; b0.key_rsp_ready = 1;
    repeat (25) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
- Time-multiplexes a single SBox byte-lookup instance between two requesters.
- Requester 1 is the round datapath's SubBytes request: a 128-bit state, 16 lookups.
- Requester 2 is the key expansion's SubWord request: a 32-bit word, 4 lookups.
- Each requester has a valid/ready request channel and a valid/ready response channel. Jobs are non-preemptive, serialized one byte per cycle, and arbitrated at job boundaries.

Parameters:
- ARB_MODE, default 0: arbitration policy. 0 = round-robin, 1 = fixed priority to key requester.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- st_req_valid  in  1  state job offered.
- st_req_ready  out  1  state job accepted this cycle when high together with st_req_valid.
- st_req_data  in  128  state bytes; byte 0 = [127:120] ... byte 15 = [7:0].
- st_rsp_valid  out  1  SubBytes result available.
- st_rsp_ready  in  1  consumer takes result.
- st_rsp_data  out  128  SubBytes result, same byte order.
- key_req_valid  in  1  key word offered.
- key_req_ready  out  1  key word accepted this cycle.
- key_req_data  in  32  word; byte 0 = [31:24].
- key_rsp_valid  out  1  SubWord result available.
- key_rsp_ready  in  1  consumer takes result.
- key_rsp_data  out  32  SubWord result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all *_ready, *_rsp_valid and busy are 0; rsp data is 0; FSM is IDLE; byte counter is 0; round-robin last-grant = state, so key wins the first tie.
- FSM state IDLE:
  - Grant selection: if exactly one req_valid is high, that requester is selected. If both are high: ARB_MODE=1 selects key; ARB_MODE=0 selects the requester not granted last.
  - Only the selected requester sees req_ready=1. Ready is combinational from the valids in IDLE only; it is 0 in every other state.
  - On handshake: latch the input data and the owner, set count=0, update last-grant, go to RUN.
- FSM state RUN, each cycle:
  - Drive byte[count] of the latched input to the SBox.
  - Register the SBox output into result byte[count].
  - Increment count.
  - When count == N-1 (N=16 for state, 4 for key), go to DONE.
- FSM state DONE:
  - The owner's rsp_valid is 1 and rsp_data holds the full result, stable until the handshake.
  - On rsp_valid && rsp_ready, go to IDLE.
  - The non-owner's rsp_valid stays 0.
- Latency: accept handshake edge = cycle 0; rsp_valid is first high in cycle N+1. That is 17 cycles for state and 5 for key.
- Throughput: after a zero-wait response, a new accept is possible the next cycle (IDLE), giving N+2 cycles per job.
- A requester dropping req_valid while not accepted has no effect; no request is buffered.
- The SBox lookup is combinational; the datapath is byte-serial. The result register is 128 bits; a key job writes only the low 4 byte slots, mapped to key_rsp_data.
- After a response handshake, rsp_data retains its last value and may be ignored.
- Reset in RUN or DONE: the job is discarded, the FSM returns to IDLE, rsp_valid drops the next cycle, and no response is produced.
- No overlap: while busy, both req_ready are 0 regardless of the valids.

Test Plan:
- Single state job, st_req_data=00112233445566778899aabbccddeeff, st_rsp_ready=1 → st_rsp_valid rises 17 cycles after accept with data 638293c31bfc33f5c4eeacea4bc12816, one cycle wide; key_rsp_valid stays 0.
- Single key job, key_req_data=cf4f3c09 → key_rsp_valid 5 cycles after accept with data 8a84eb01.
- Both valid from reset, ARB_MODE=0 → key accepted first. Then the state job is accepted in the IDLE cycle after the key response. A further tie with both valid is granted to key again (alternation). With ARB_MODE=1, key is always chosen on ties.
- Backpressure: hold st_rsp_ready=0 for 10 cycles after st_rsp_valid → data stable, busy=1, key_req_ready=0 throughout. Release → handshake, then IDLE.
- Reset asserted in the 8th RUN cycle of a state job → next cycle busy=0 and both rsp_valid=0. A subsequent key job 09cf4f3c returns 01 8a 84 eb = 018a84eb.
- Exhaustive lookup: 64 state jobs covering bytes 00..ff are checked against the FIPS-197 S-box (e.g. 53→ed, 52→00, ff→16).
